// File: rtl/poly_mod_sq_iter_if.sv
// Job request, result and external-squarer signals of poly_mod_sq_iter.
// slave is the engine side, master the job source / squarer side.
interface poly_mod_sq_iter_if #(
    parameter int WORD_BITS       = 16,
    parameter int NUM_WORDS       = 8,
    parameter int REDUN_WORD_BITS = 1,
    parameter int I_WORD          = NUM_WORDS + 1,
    parameter int ITER_BITS       = 32
);
    localparam int W  = WORD_BITS * NUM_WORDS;
    localparam int PW = I_WORD * (WORD_BITS + REDUN_WORD_BITS);

    logic                 i_val;
    logic                 o_rdy;
    logic [W-1:0]         i_dat;
    logic [ITER_BITS-1:0] i_iter;
    logic                 o_sq_val;
    logic [PW-1:0]        o_sq_dat;
    logic                 i_sq_val;
    logic [PW-1:0]        i_sq_dat;
    logic                 o_val;
    logic                 i_rdy;
    logic [W-1:0]         o_dat;
    logic                 o_err;

    modport master (
        output i_val, i_dat, i_iter, i_sq_val, i_sq_dat, i_rdy,
        input  o_rdy, o_sq_val, o_sq_dat, o_val, o_dat, o_err
    );

    modport slave (
        input  i_val, i_dat, i_iter, i_sq_val, i_sq_dat, i_rdy,
        output o_rdy, o_sq_val, o_sq_dat, o_val, o_dat, o_err
    );
endinterface

// File: rtl/poly_mod_sq_iter.sv
// Iterated modular squaring x^(2^T) mod MODULUS around an external squarer,
// followed by carry normalisation and bounded final reduction.
module poly_mod_sq_iter #(
    parameter int WORD_BITS       = 16,
    parameter int NUM_WORDS       = 8,
    parameter int REDUN_WORD_BITS = 1,
    parameter int I_WORD          = NUM_WORDS + 1,
    parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS =
        {1'b0, {(WORD_BITS*NUM_WORDS-1){1'b1}}} - 9,
    parameter int ITER_BITS       = 32,
    parameter int MAX_SUB         = 8
) (
    input logic               i_clk,
    input logic               i_rst_n,
    poly_mod_sq_iter_if.slave bus
);
    localparam int W    = WORD_BITS * NUM_WORDS;
    localparam int C    = WORD_BITS + REDUN_WORD_BITS;
    localparam int PW   = I_WORD * C;
    localparam int AW   = I_WORD * WORD_BITS + C;
    localparam int LOW  = (I_WORD - 1) * WORD_BITS;
    localparam int TOPW = AW - LOW;
    localparam int IDXW = $clog2(I_WORD + 1);
    localparam int SUBW = $clog2(MAX_SUB + 1);
    localparam int CYW  = REDUN_WORD_BITS + 1;

    typedef enum logic [2:0] {
        IDLE, SQ_REQ, SQ_WAIT, NORM, REDUCE, DONE
    } state_t;

    state_t               state;
    state_t               nxt;
    logic                 live;
    logic [ITER_BITS-1:0] cnt;
    logic [PW-1:0]        poly;
    logic [PW-1:0]        init_poly;
    logic [AW-1:0]        acc;
    logic [CYW-1:0]       carry;
    logic [IDXW-1:0]      idx;
    logic [SUBW-1:0]      subcnt;
    logic [W-1:0]         dat;
    logic                 err;

    logic                 rdy;
    logic                 sq_val;
    logic                 val;
    logic                 accept;
    logic                 sq_take;
    logic                 norm_last;
    logic                 ge;
    logic                 can_sub;
    logic [C:0]           sum;

    always_comb begin
        init_poly = '0;
        for (int i = 0; i < NUM_WORDS; i++)
            init_poly[i*C +: WORD_BITS] =
                bus.i_dat[i*WORD_BITS +: WORD_BITS];
    end

    // live keeps o_rdy low while reset is held, high from the first edge after
    assign accept    = rdy && bus.i_val;
    assign sq_take   = (state == SQ_WAIT) && bus.i_sq_val;
    assign norm_last = idx == IDXW'(I_WORD - 1);
    assign ge        = acc >= AW'(MODULUS);
    assign can_sub   = ge && (subcnt < SUBW'(MAX_SUB));
    assign sum       = {1'b0, poly[C-1:0]} + (C+1)'(carry);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt    = state;
        rdy    = 1'b0;
        sq_val = 1'b0;
        val    = 1'b0;
        unique case (state)
            IDLE: begin
                rdy = live;
                if (live && bus.i_val)
                    nxt = (bus.i_iter != '0) ? SQ_REQ : NORM;
            end
            SQ_REQ: begin
                sq_val = 1'b1;
                nxt    = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (bus.i_sq_val)
                    nxt = (cnt != ITER_BITS'(1)) ? SQ_REQ : NORM;
            end
            NORM: begin
                if (norm_last) nxt = REDUCE;
            end
            REDUCE: begin
                if (!can_sub) nxt = DONE;
            end
            DONE: begin
                val = 1'b1;
                if (bus.i_rdy) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            live   <= 1'b0;
            cnt    <= '0;
            poly   <= '0;
            acc    <= '0;
            carry  <= '0;
            idx    <= '0;
            subcnt <= '0;
            dat    <= '0;
            err    <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                poly <= init_poly;
                cnt  <= bus.i_iter;
            end
            if (sq_take) begin
                poly <= bus.i_sq_dat;
                cnt  <= cnt - 1'b1;
            end
            // one coefficient per cycle, lowest first; top slot keeps all carries
            if (state == NORM) begin
                poly  <= poly >> C;
                carry <= sum[C:WORD_BITS];
                idx   <= idx + 1'b1;
                if (norm_last)
                    acc[AW-1:LOW] <= TOPW'(sum);
                else
                    acc[idx*WORD_BITS +: WORD_BITS] <= sum[WORD_BITS-1:0];
            end else begin
                carry <= '0;
                idx   <= '0;
            end
            if (state == REDUCE) begin
                if (can_sub) begin
                    acc    <= acc - AW'(MODULUS);
                    subcnt <= subcnt + 1'b1;
                end else begin
                    dat <= acc[W-1:0];
                    err <= ge;
                end
            end else begin
                subcnt <= '0;
            end
        end
    end

    assign bus.o_rdy    = rdy;
    assign bus.o_sq_val = sq_val;
    assign bus.o_sq_dat = poly;
    assign bus.o_val    = val;
    assign bus.o_dat    = dat;
    assign bus.o_err    = err;
endmodule

// File: tb/tb_poly_mod_sq_iter.sv
// Directed bench for poly_mod_sq_iter: vector table, squarer model with
// redundant/offset replies, plus reset and back-pressure sequences.
module tb_poly_mod_sq_iter;
    localparam int WB = 16;
    localparam int NW = 8;
    localparam int RB = 1;
    localparam int IW = NW + 1;
    localparam int IB = 32;
    localparam int W  = WB * NW;
    localparam int C  = WB + RB;
    localparam int PW = IW * C;
    localparam int NV = 10;
    localparam logic [W-1:0] MOD = (128'd1 << 127) - 128'd10;

    typedef struct {
        logic [W-1:0]  x;
        logic [IB-1:0] t;
        int            mode;
        logic [W-1:0]  dat;
        logic          err;
        int            lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   sq_pulses = 0;
    int   sq_mode = 0;
    bit   sq_en = 1;
    bit   inject_req = 0;

    poly_mod_sq_iter_if #(
        .WORD_BITS(WB), .NUM_WORDS(NW), .REDUN_WORD_BITS(RB),
        .I_WORD(IW), .ITER_BITS(IB)
    ) bus ();

    poly_mod_sq_iter dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Squarer model: replies one cycle after o_sq_val with a value congruent
    // to the square, optionally offset by k*MOD and in redundant digit form.
    initial begin : squarer
        logic [PW-1:0]  snap;
        logic [PW-1:0]  rsp;
        logic [319:0]   p;
        logic [C-1:0]   d [IW];
        bit             injected;
        injected = 0;
        bus.i_sq_val = 1'b0;
        bus.i_sq_dat = '0;
        forever begin
            @(negedge clk);
            if (inject_req && !injected) begin
                injected = 1;
                bus.i_sq_dat = '1;
                bus.i_sq_val = 1'b1;
                repeat (4) @(negedge clk);
                bus.i_sq_val = 1'b0;
            end else if (bus.o_sq_val === 1'b1) begin
                sq_pulses++;
                if (sq_en) begin
                    snap = bus.o_sq_dat;
                    p = '0;
                    for (int i = 0; i < IW; i++)
                        p = p + (320'(snap[i*C +: C]) << (WB * i));
                    p = (p * p) % 320'(MOD);
                    if (sq_mode == 1)
                        p = p + 320'(MOD) * 320'($urandom_range(1, 3));
                    else if (sq_mode == 2)
                        p = p + 320'(MOD) * 320'(20);
                    for (int i = 0; i < IW; i++)
                        d[i] = C'(p[i*WB +: WB]);
                    if (sq_mode != 0)
                        for (int i = 0; i < IW - 1; i++)
                            if (d[i+1] != '0 && $urandom_range(0, 1) == 1) begin
                                d[i+1] = d[i+1] - 1'b1;
                                d[i]   = d[i] + C'(1 << WB);
                            end
                    for (int i = 0; i < IW; i++)
                        rsp[i*C +: C] = d[i];
                    @(posedge clk); #1;
                    bus.i_sq_dat = rsp;
                    bus.i_sq_val = 1'b1;
                    check("sq_dat_hold", bus.o_sq_dat, snap);
                    @(posedge clk); #1;
                    bus.i_sq_val = 1'b0;
                end
            end
        end
    end

    task automatic wait_rdy();
        int n;
        n = 0;
        while (bus.o_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("job_rdy", bus.o_rdy, 1'b1);
    endtask

    task automatic run_job(input logic [W-1:0] x, input logic [IB-1:0] t,
                           output logic [W-1:0] dat, output logic err,
                           output int lat);
        wait_rdy();
        bus.i_dat  = x;
        bus.i_iter = t;
        bus.i_val  = 1'b1;
        @(posedge clk); #1;
        bus.i_val = 1'b0;
        lat = 1;
        while (bus.o_val !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("job_val", bus.o_val, 1'b1);
        dat = bus.o_dat;
        err = bus.o_err;
        @(posedge clk); #1;
    endtask

    vec_t         vecs [NV];
    logic [W-1:0] dat;
    logic         err;
    int           lat;
    int           p0;
    int           n;
    bit           seen_val;

    initial begin
        vecs[0] = '{2, 1, 0, 4, 0, 13};
        vecs[1] = '{3, 1, 0, 9, 0, 13};
        vecs[2] = '{5, 0, 0, 5, 0, 11};
        vecs[3] = '{MOD - 1, 0, 0, MOD - 1, 0, 11};
        vecs[4] = '{MOD, 0, 0, 0, 0, 12};
        vecs[5] = '{MOD + 3, 0, 0, 3, 0, 12};
        vecs[6] = '{{W{1'b1}}, 0, 0, 19, 0, 13};
        vecs[7] = '{2, 7, 1, 20, 0, 0};
        vecs[8] = '{3, 2, 1, 81, 0, 0};
        vecs[9] = '{2, 1, 2, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF8C, 1, 21};

        bus.i_val  = 1'b0;
        bus.i_dat  = '0;
        bus.i_iter = '0;
        bus.i_rdy  = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_rdy", bus.o_rdy, 1'b0);
        check("rst_val", bus.o_val, 1'b0);
        check("rst_sq_val", bus.o_sq_val, 1'b0);
        check("rst_dat", bus.o_dat, '0);
        check("rst_err", bus.o_err, 1'b0);
        check("rst_sq_dat", bus.o_sq_dat, '0);
        repeat (2) @(posedge clk);
        #1 check("rst_rdy_held", bus.o_rdy, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rdy_first_edge", bus.o_rdy, 1'b1);

        for (int v = 0; v < NV; v++) begin
            sq_mode = vecs[v].mode;
            p0 = sq_pulses;
            run_job(vecs[v].x, vecs[v].t, dat, err, lat);
            check($sformatf("v%0d_dat", v), dat, vecs[v].dat);
            check($sformatf("v%0d_err", v), err, vecs[v].err);
            check($sformatf("v%0d_sq_pulses", v), sq_pulses - p0, vecs[v].t);
            if (vecs[v].lat != 0)
                check($sformatf("v%0d_lat", v), lat, vecs[v].lat);
        end

        // reset while waiting on the squarer, then a stale squarer reply
        sq_mode = 0;
        sq_en = 0;
        wait_rdy();
        bus.i_dat  = 2;
        bus.i_iter = 1;
        bus.i_val  = 1'b1;
        @(posedge clk); #1;
        bus.i_val = 1'b0;
        check("c_sq_req", bus.o_sq_val, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("c_rst_rdy", bus.o_rdy, 1'b0);
        check("c_rst_sq_val", bus.o_sq_val, 1'b0);
        check("c_rst_val", bus.o_val, 1'b0);
        check("c_rst_err", bus.o_err, 1'b0);
        check("c_rst_dat", bus.o_dat, '0);
        check("c_rst_sq_dat", bus.o_sq_dat, '0);
        inject_req = 1;
        seen_val = 0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (bus.o_val === 1'b1 || bus.o_sq_val === 1'b1) seen_val = 1;
        end
        check("c_no_val", seen_val, 1'b0);
        check("c_rdy", bus.o_rdy, 1'b1);
        sq_en = 1;
        run_job(3, 1, dat, err, lat);
        check("c_dat", dat, 9);
        check("c_err", err, 1'b0);

        // result held under back-pressure, stray requests ignored mid-job
        bus.i_rdy = 1'b0;
        wait_rdy();
        bus.i_dat  = 3;
        bus.i_iter = 1;
        bus.i_val  = 1'b1;
        @(posedge clk); #1;
        bus.i_dat  = 7;
        bus.i_iter = 0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus.i_val = 1'b0;
        n = 0;
        while (bus.o_val !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_val", bus.o_val, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("b_hold_val", bus.o_val, 1'b1);
            check("b_hold_dat", bus.o_dat, 9);
            check("b_hold_rdy", bus.o_rdy, 1'b0);
        end
        bus.i_rdy = 1'b1;
        #1 check("b_rdy_in_hs", bus.o_rdy, 1'b0);
        @(posedge clk); #1;
        check("b_val_after", bus.o_val, 1'b0);
        check("b_rdy_after", bus.o_rdy, 1'b1);
        run_job(5, 0, dat, err, lat);
        check("b2_dat", dat, 5);
        check("b2_lat", lat, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
